// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS32 core.
// Owns the PC, applies decode-stage redirects and load-use stalls, and drains the pipe on stop.

module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned HALT_DRAIN = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        StallF,
    input  logic        BranchD,
    input  logic [1:0]  SrcPCD,
    input  logic [31:0] BranchOffsetD,
    input  logic [31:0] JrTargetD,
    input  logic        StopD,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemData,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        Halted
);

    localparam int unsigned CntW = 4;
    localparam logic [CntW-1:0] DrainInit = CntW'(HALT_DRAIN - 1);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StHalt  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     pc_plus4_q, pc_plus4_d;
    logic            valid_q, valid_d;
    logic            halted_q, halted_d;

    logic [31:0]     pc_plus4;
    logic [31:0]     branch_target;
    logic [31:0]     jump_target;
    logic [31:0]     redirect_target;
    logic            redirect;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4_q + (BranchOffsetD << 2);
    // Jump target comes from the IF/ID copy of the instruction, not from the memory port.
    assign jump_target   = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
    assign redirect      = BranchD && (SrcPCD != 2'b00);

    always_comb begin
        redirect_target = pc_plus4;
        unique case (SrcPCD)
            2'b01:   redirect_target = branch_target;
            2'b10:   redirect_target = jump_target;
            2'b11:   redirect_target = JrTargetD;
            default: redirect_target = pc_plus4;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        halted_d   = halted_q;

        unique case (state_q)
            StRun: begin
                if (StallF) begin
                    // Stall outranks redirect and stop; both are re-sampled once it clears.
                end else if (redirect) begin
                    pc_d       = redirect_target;
                    instr_d    = 32'h0;
                    pc_plus4_d = 32'h0;
                    valid_d    = 1'b0;
                end else if (StopD && valid_q) begin
                    state_d    = StDrain;
                    cnt_d      = DrainInit;
                    instr_d    = 32'h0;
                    pc_plus4_d = 32'h0;
                    valid_d    = 1'b0;
                end else begin
                    pc_d       = pc_plus4;
                    instr_d    = ImemData;
                    pc_plus4_d = pc_plus4;
                    valid_d    = 1'b1;
                end
            end
            StDrain: begin
                instr_d    = 32'h0;
                pc_plus4_d = 32'h0;
                valid_d    = 1'b0;
                if (cnt_q == '0) begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHalt: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StRun;
            cnt_q      <= '0;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
        end
    end

    assign ImemAddr = pc_q;
    assign InstrD   = instr_q;
    assign PCPlus4D = pc_plus4_q;
    assign ValidD   = valid_q;
    assign Halted   = halted_q;

endmodule
